// File: rtl/updown_scan_ctrl_pkg.sv
// Shared types and defaults for the up/down triangle-scan sequencer.
// The state encodings are named here so that any debug decode can use the same values.
package updown_scan_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefRepsWidth = 8;

    localparam logic [2:0] EncIdle = 3'd0;
    localparam logic [2:0] EncLoad = 3'd1;
    localparam logic [2:0] EncUp   = 3'd2;
    localparam logic [2:0] EncDown = 3'd3;
    localparam logic [2:0] EncDone = 3'd4;

    typedef enum logic [2:0] {
        StIdle = EncIdle,
        StLoad = EncLoad,
        StUp   = EncUp,
        StDown = EncDown,
        StDone = EncDone
    } state_e;

endpackage

// File: rtl/updown_scan_ctrl_if.sv
// Control and readback wiring between the scan sequencer and the bidirectional counter stage.
interface updown_scan_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  PE_n;
    logic                  U_D;
    logic                  CEP_n;
    logic                  CET_n;
    logic [DATA_WIDTH-1:0] P;
    logic [DATA_WIDTH-1:0] Q_fb;
    logic                  TC_fb;

    modport master (
        output PE_n, U_D, CEP_n, CET_n, P,
        input  Q_fb, TC_fb
    );

    modport slave (
        input  PE_n, U_D, CEP_n, CET_n, P,
        output Q_fb, TC_fb
    );
endinterface

// File: rtl/updown_scan_ctrl.sv
// Triangle-scan sequencer: loads lo into the counter, then counts lo->hi->lo for a set number of
// sweeps (0 = until stopped), aborting on stop or on an impossible terminal count.
module updown_scan_ctrl
    import updown_scan_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned REPS_WIDTH = DefRepsWidth
) (
    input  logic                  clk,
    input  logic                  MR_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [DATA_WIDTH-1:0] lo,
    input  logic [DATA_WIDTH-1:0] hi,
    input  logic [REPS_WIDTH-1:0] reps,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [REPS_WIDTH-1:0] sweep_cnt,
    updown_scan_ctrl_if.master    cnt_if
);

    localparam logic [DATA_WIDTH-1:0] DataOne = DATA_WIDTH'(1);
    localparam logic [REPS_WIDTH-1:0] RepsOne = REPS_WIDTH'(1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [REPS_WIDTH-1:0] reps_q, reps_d;
    logic [REPS_WIDTH-1:0] sweep_q, sweep_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] hi_m1;
    logic [DATA_WIDTH-1:0] lo_p1;

    // lo < hi is guaranteed once latched, so neither of these can wrap.
    assign hi_m1 = hi_q - DataOne;
    assign lo_p1 = lo_q + DataOne;

    always_ff @(posedge clk or negedge MR_n) begin
        if (!MR_n) begin
            state_q <= StIdle;
            lo_q    <= '0;
            hi_q    <= '0;
            reps_q  <= '0;
            sweep_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            reps_q  <= reps_d;
            sweep_q <= sweep_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        reps_d  = reps_q;
        sweep_d = sweep_q;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (lo < hi) begin
                        lo_d    = lo;
                        hi_d    = hi;
                        reps_d  = reps;
                        sweep_d = '0;
                        state_d = StLoad;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            StLoad: begin
                state_d = stop ? StIdle : StUp;
            end

            StUp: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (cnt_if.TC_fb) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else if (cnt_if.Q_fb == hi_m1) begin
                    state_d = StDown;
                end
            end

            StDown: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (cnt_if.TC_fb) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else if (cnt_if.Q_fb == lo_p1) begin
                    sweep_d = sweep_q + RepsOne;
                    if ((reps_q != '0) && (sweep_d == reps_q)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StUp;
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Moore outputs: everything below depends only on registered state.
    always_comb begin
        cnt_if.PE_n  = (state_q != StLoad);
        cnt_if.U_D   = (state_q != StDown);
        cnt_if.CEP_n = !((state_q == StUp) || (state_q == StDown));
        cnt_if.CET_n = !((state_q == StUp) || (state_q == StDown));
        cnt_if.P     = lo_q;
        busy         = (state_q == StLoad) || (state_q == StUp) || (state_q == StDown);
        done         = (state_q == StDone);
        err          = err_q;
        sweep_cnt    = sweep_q;
    end

endmodule

// File: tb/tb_updown_scan_ctrl.sv
// Closed-loop bench: a behavioural counter stage answers the sequencer, and a scoreboard compares
// every count, load and completion event against a triangle-wave reference model.
module tb_updown_scan_ctrl;
    import updown_scan_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned RW = 8;

    logic          clk   = 1'b0;
    logic          MR_n  = 1'b1;
    logic          start = 1'b0;
    logic          stop  = 1'b0;
    logic [DW-1:0] lo    = '0;
    logic [DW-1:0] hi    = '0;
    logic [RW-1:0] reps  = '0;
    logic          busy, done, err;
    logic [RW-1:0] sweep_cnt;
    logic          force_tc = 1'b0;
    logic [DW-1:0] cnt_q = '0;

    updown_scan_ctrl_if #(.DATA_WIDTH(DW)) cif ();

    updown_scan_ctrl #(.DATA_WIDTH(DW), .REPS_WIDTH(RW)) dut (
        .clk       (clk),
        .MR_n      (MR_n),
        .start     (start),
        .stop      (stop),
        .lo        (lo),
        .hi        (hi),
        .reps      (reps),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .sweep_cnt (sweep_cnt),
        .cnt_if    (cif)
    );

    // Counter stage: synchronous load, count when both enables are low, not reset by MR_n.
    always @(posedge clk) begin
        if (!cif.PE_n) cnt_q <= cif.P;
        else if (!cif.CEP_n && !cif.CET_n) cnt_q <= cif.U_D ? cnt_q + 8'd1 : cnt_q - 8'd1;
    end
    assign cif.Q_fb  = cnt_q;
    assign cif.TC_fb = force_tc | (!cif.CET_n && (cif.U_D ? (cnt_q == 8'hff) : (cnt_q == 8'h00)));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    typedef struct {
        bit is_done;
        int sweeps;
        int q;
    } ev_t;

    int  ld_exp[$];
    int  cnt_exp[$];   // up*256 + q for every enabled cycle
    ev_t ev_exp[$];
    int  model_sweep = 0;

    function automatic int tri_val(input int l, input int h, input int k);
        int span = h - l;
        int p    = k % (2 * span);
        return (p < span) ? l + p : h - (p - span);
    endfunction

    function automatic int tri_up(input int l, input int h, input int k);
        int span = h - l;
        return ((k % (2 * span)) < span) ? 1 : 0;
    endfunction

    initial begin : monitor
        int  e;
        ev_t ev;
        forever begin
            @(negedge clk);
            if (MR_n) begin
                if (!cif.PE_n) begin
                    check("load_expected", int'(ld_exp.size() > 0), 1);
                    if (ld_exp.size() > 0) begin
                        check("load_P", cif.P, ld_exp.pop_front());
                        check("load_enables_off", cif.CEP_n, 1);
                    end
                end
                if (!cif.CEP_n) begin
                    check("cet_eq_cep", cif.CET_n, cif.CEP_n);
                    check("count_expected", int'(cnt_exp.size() > 0), 1);
                    if (cnt_exp.size() > 0) begin
                        e = cnt_exp.pop_front();
                        check("count_q", cif.Q_fb, e % 256);
                        check("count_dir", cif.U_D, e / 256);
                    end
                end
                if (done || err) begin
                    check("event_expected", int'(ev_exp.size() > 0), 1);
                    check("event_not_both", int'(done && err), 0);
                    if (ev_exp.size() > 0) begin
                        ev = ev_exp.pop_front();
                        check("event_is_done", done, ev.is_done);
                        check("event_sweeps", sweep_cnt, ev.sweeps);
                        if (ev.is_done) begin
                            check("done_q_at_lo", cif.Q_fb, ev.q);
                            check("done_busy_low", busy, 0);
                            check("done_enables_off", cif.CEP_n, 1);
                        end
                    end
                end
            end
        end
    end

    // stop_k / fault_k: enabled-cycle index at which stop / TC fault is injected, -1 for none.
    task automatic run_scan(input int l, input int h, input int r, input int stop_k,
                            input int fault_k);
        int  span2, last, idx, cycles;
        ev_t ev;
        @(negedge clk);
        lo = DW'(l); hi = DW'(h); reps = RW'(r); start = 1'b1;
        if (l < h) begin
            span2 = 2 * (h - l);
            last  = (stop_k >= 0) ? stop_k : (fault_k >= 0) ? fault_k : r * span2 - 1;
            ld_exp.push_back(l);
            for (int k = 0; k <= last; k++)
                cnt_exp.push_back(tri_up(l, h, k) * 256 + tri_val(l, h, k));
            if (stop_k < 0) begin
                ev.is_done = (fault_k < 0);
                ev.sweeps  = (fault_k < 0) ? r % 256 : (fault_k / span2) % 256;
                ev.q       = l;
                ev_exp.push_back(ev);
            end
            model_sweep = ((last + 1 - ((stop_k >= 0 || fault_k >= 0) ? 1 : 0)) / span2) % 256;
        end else begin
            ev.is_done = 1'b0;
            ev.sweeps  = model_sweep;
            ev.q       = 0;
            ev_exp.push_back(ev);
        end
        @(negedge clk);
        start = 1'b0;
        if (l >= h) begin
            check("rej_err_pulse", err, 1);
            check("rej_busy_low", busy, 0);
            check("rej_pe_n_high", cif.PE_n, 1);
            @(negedge clk);
            check("rej_err_one_cycle", err, 0);
            check("rej_still_idle", busy, 0);
            return;
        end
        check("load_after_start", cif.PE_n, 0);
        check("busy_in_load", busy, 1);
        idx = 0;
        cycles = 0;
        while (cycles < 3000) begin
            @(negedge clk);
            cycles++;
            stop = 1'b0; force_tc = 1'b0; start = 1'b0;
            if (!busy) break;
            if (!cif.CEP_n) begin
                if (idx == stop_k) stop = 1'b1;
                if (idx == fault_k) force_tc = 1'b1;
                // A start while busy must be ignored, even with illegal limits.
                if (idx == 1) begin start = 1'b1; lo = 8'hff; hi = 8'h00; end
                idx++;
            end
        end
        check("scan_in_budget", int'(cycles < 3000), 1);
        if (stop_k < 0 && fault_k < 0) begin
            check("done_latency", cycles, r * span2 + 1);
        end else begin
            check("abort_enables_off", cif.CEP_n, 1);
            check("abort_pe_n_high", cif.PE_n, 1);
        end
        if (stop_k >= 0) begin
            check("stop_no_err", err, 0);
            check("stop_no_done", done, 0);
            check("stop_q_held", cif.Q_fb, tri_val(l, h, stop_k + 1));
            check("stop_sweeps", sweep_cnt, (stop_k / span2) % 256);
        end
        @(negedge clk);
        check("idle_after_scan", busy, 0);
        check("counts_drained", cnt_exp.size(), 0);
        check("events_drained", ev_exp.size(), 0);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int l, h, r, mode, total, k;
        #1 MR_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_pe_n", cif.PE_n, 1);
        check("rst_u_d", cif.U_D, 1);
        check("rst_cep_n", cif.CEP_n, 1);
        check("rst_cet_n", cif.CET_n, 1);
        check("rst_p", cif.P, 0);
        check("rst_sweep", sweep_cnt, 0);
        check("rst_done_err", int'(done || err), 0);
        MR_n = 1'b1;

        run_scan(3, 5, 2, -1, -1);
        check("sweeps_after_3_5", sweep_cnt, 2);
        run_scan(0, 255, 1, -1, -1);
        run_scan(7, 7, 1, -1, -1);
        run_scan(9, 4, 1, -1, -1);
        run_scan(10, 12, 0, 3, -1);
        run_scan(1, 4, 1, -1, 1);
        run_scan(1, 4, 1, 1, 1);
        run_scan(20, 21, 0, 600, -1);   // sweep counter wraps past 255
        run_scan(20, 21, 3, -1, -1);

        // stop in IDLE is ignored
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        check("stop_idle_ignored", busy, 0);
        check("stop_idle_no_err", err, 0);

        // Asynchronous reset mid-UP, checked before the next clock edge.
        @(negedge clk); lo = 8'd5; hi = 8'd40; reps = 8'd1; start = 1'b1;
        ld_exp.push_back(5);
        for (int i = 0; i < 70; i++) cnt_exp.push_back(tri_up(5, 40, i) * 256 + tri_val(5, 40, i));
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_counting", cif.CEP_n, 0);
        #2 MR_n = 1'b0;
        #1;
        check("amr_busy", busy, 0);
        check("amr_pe_n", cif.PE_n, 1);
        check("amr_u_d", cif.U_D, 1);
        check("amr_enables", int'(cif.CEP_n && cif.CET_n), 1);
        check("amr_p", cif.P, 0);
        check("amr_sweep", sweep_cnt, 0);
        ld_exp.delete(); cnt_exp.delete(); ev_exp.delete();
        model_sweep = 0;
        @(negedge clk);
        MR_n = 1'b1;
        run_scan(2, 3, 1, -1, -1);

        for (int it = 0; it < 24; it++) begin
            mode = $urandom_range(0, 4);
            l = $urandom_range(0, 250);
            h = $urandom_range(l + 1, (l + 12 > 255) ? 255 : l + 12);
            r = $urandom_range(0, 3);
            total = ((r == 0) ? 3 : r) * 2 * (h - l);
            k = $urandom_range(0, total - 1);
            case (mode)
                0: run_scan(l, h, r, (r == 0) ? k : -1, -1);
                1: run_scan(l, h, r, k, -1);
                2: run_scan(l, h, r, -1, k);
                3: run_scan(l, h, r, k, k);
                default: run_scan(h, l, r, -1, -1);
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/updown_scan_ctrl.md
Name: updown_scan_ctrl

Overview:
Upstream sequencer for the 8-bit bidirectional binary counter stage. It drives the counter's PE_n, U_D, CEP_n, CET_n and P inputs, and reads back Q and TC. From a single start pulse it produces a triangle scan lo→hi→lo, repeated a programmable number of sweeps. Typical uses are address or DAC ramps built from TTL-style counter stages.

Parameters:
DATA_WIDTH, 8, width of the counter, lo/hi limits and P/Q_fb buses
REPS_WIDTH, 8, width of the repeat count and sweep counter

Ports:
clk  in  1  system clock; all state changes on rising edge
MR_n  in  1  asynchronous active-low master reset
start  in  1  begin a scan; sampled only in IDLE
stop  in  1  abort the scan; sampled in LOAD/UP/DOWN
lo  in  DATA_WIDTH  lower scan limit, latched on accepted start
hi  in  DATA_WIDTH  upper scan limit, latched on accepted start
reps  in  REPS_WIDTH  full sweeps to run (lo→hi→lo); 0 = continuous; latched on start
Q_fb  in  DATA_WIDTH  counter Q readback
TC_fb  in  1  counter terminal-count readback
PE_n  out  1  counter parallel-load, active low
U_D  out  1  counter direction; 1 = up
CEP_n  out  1  counter enable, active low
CET_n  out  1  counter enable, active low; always equal to CEP_n
P  out  DATA_WIDTH  counter load data; carries lo_r
busy  out  1  high in LOAD/UP/DOWN
done  out  1  one-cycle pulse on normal completion
err  out  1  one-cycle pulse on rejected start or fault abort
sweep_cnt  out  REPS_WIDTH  number of completed sweeps

Behaviour:
- Reset (MR_n=0, asynchronous):
  - state=IDLE; lo_r, hi_r, reps_r, sweep_cnt = 0.
  - Outputs: PE_n=1, U_D=1, CEP_n=CET_n=1, P=0, busy=0, done=0, err=0.
  - Reset asserted mid-scan behaves the same way; the counter is left holding its value.
- Outputs are Moore-decoded from registered state. P = lo_r at all times.
- States:
  - IDLE: counter disabled, PE_n=1.
    - start with lo<hi: latch lo/hi/reps, clear sweep_cnt, go to LOAD.
    - start with lo>=hi: err pulse next cycle, stay in IDLE.
  - LOAD, 1 cycle: PE_n=0, enables off. The counter loads lo at this edge; go to UP.
  - UP: U_D=1, CEP_n=CET_n=0.
    - If Q_fb==hi_r-1, go to DOWN; Q becomes hi at the same edge.
  - DOWN: U_D=0, CEP_n=CET_n=0.
    - If Q_fb==lo_r+1, the sweep completes: sweep_cnt+1.
    - Then, if reps_r!=0 and sweep_cnt+1==reps_r, go to DONE; otherwise go to UP.
  - DONE, 1 cycle: done=1, enables off, Q holds lo. Go to IDLE.
- Latency: start edge → LOAD. The first counted value lo appears one cycle later. Each sweep takes exactly 2*(hi-lo) cycles in UP/DOWN. done asserts in the cycle after the last DOWN edge.
- Width/arithmetic:
  - hi_r-1 and lo_r+1 are computed at DATA_WIDTH bits. No wrap is possible because lo<hi.
  - sweep_cnt wraps modulo 2^REPS_WIDTH in continuous mode.
- Fault guard: TC_fb cannot assert in UP or DOWN during legal operation (Q stays ≤ hi-1 going up and ≥ lo+1 going down). If TC_fb=1 in UP or DOWN, abort to IDLE with an err pulse and no done.
- stop in LOAD/UP/DOWN → IDLE at the next edge. Enables deassert, the counter holds its value, no done, no err.
- Priority when events coincide in one cycle: MR_n > stop > TC_fb fault > turn-around/completion.
- stop in IDLE is ignored. start outside IDLE is ignored.
- lo=hi-1 is legal: one cycle in UP, then one cycle in DOWN per sweep.

Decomposition:
- Package updown_scan_pkg holds:
  - state enum: IDLE, LOAD, UP, DOWN, DONE;
  - localparam encodings;
  - default widths.
- No sub-module; this is a single FSM plus datapath registers.
- The testbench closes the loop with the existing counter model as the DUT's partner.

Test Plan:
- lo=3, hi=5, reps=2 → Q sequence 3,4,5,4,3,4,5,4,3; done pulses once, 9 cycles after LOAD; sweep_cnt=2; busy falls with done.
- lo=0, hi=255, reps=1 → full ramp 0..255..0 in 510 counting cycles; TC_fb never faults; done=1.
- lo=7, hi=7 start → err pulse 1 cycle later, PE_n stays 1, busy=0; lo=9, hi=4 gives the same response.
- reps=0 with lo=10, hi=12, stop asserted when Q=11 in DOWN → IDLE next edge, Q held at 10, no done; sweep_cnt shows the completed count.
- Force TC_fb=1 during UP (lo=1, hi=4) → err pulse, IDLE, enables off. Repeat with stop high in the same cycle → IDLE with no err.
- MR_n low asynchronously mid-UP → outputs at reset values immediately, without waiting for a clk edge; release, then start lo=2, hi=3, reps=1 → Q 2,3,2 then done.
